// File: rtl/serial_alu_ctrl_if.sv
// Start/done handshake and operand/result bus of the bit-serial ALU sequencer.
// The overflow flag exists only when SERIAL_ALU_OVF_EN is defined.
interface serial_alu_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
`ifdef SERIAL_ALU_OVF_EN
  logic             overflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, carry_out, overflow
  );
  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, carry_out, overflow
  );
`else
  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, carry_out
  );
  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, carry_out
  );
`endif
endinterface

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one operand bit pair per clock through a 1-bit AND/OR/adder cell.
// Optional signed-overflow flag enabled by defining SERIAL_ALU_OVF_EN.
module serial_alu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  serial_alu_ctrl_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             cell_bit;
  logic             cell_carry;
  logic             arith;
  logic [WIDTH-1:0] res_next;

  // The 1-bit slice: B is already inverted for SUB, so SUB uses the adder path.
  always_comb begin
    cell_bit   = 1'b0;
    cell_carry = carry;
    arith      = op_q[1];
    case (op_q)
      OP_AND: cell_bit = a_sr[0] & b_sr[0];
      OP_OR:  cell_bit = a_sr[0] | b_sr[0];
      default: begin
        cell_bit   = a_sr[0] ^ b_sr[0] ^ carry;
        cell_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
      end
    endcase
    res_next = {cell_bit, res_sr[WIDTH-1:1]};
  end

  assign bus.result = res_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= OP_AND;
      a_sr          <= '0;
      b_sr          <= '0;
      res_sr        <= '0;
      cnt           <= '0;
      carry         <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.zero      <= 1'b0;
      bus.carry_out <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      bus.overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr          <= bus.a;
            b_sr          <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
            carry         <= (bus.op == OP_SUB);
            op_q          <= op_t'(bus.op);
            cnt           <= '0;
            res_sr        <= '0;
            bus.zero      <= 1'b0;
            bus.carry_out <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            bus.overflow  <= 1'b0;
`endif
            bus.busy      <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          carry  <= cell_carry;
          if (cnt == CW'(WIDTH - 1)) begin
            // carry still holds the carry into the MSB during this last bit
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.zero      <= (res_next == '0);
            bus.carry_out <= arith & cell_carry;
`ifdef SERIAL_ALU_OVF_EN
            bus.overflow  <= arith & (carry ^ cell_carry);
`endif
            state         <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed-vector bench for serial_alu_ctrl (WIDTH=32); checks timing, results, flags and reset abort.
// Overflow checks compile in only when SERIAL_ALU_OVF_EN is defined.
module tb_serial_alu_ctrl;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;

  serial_alu_ctrl_if #(.WIDTH(32)) bus();

  serial_alu_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Presents one operation for exactly one sampled cycle; returns in cycle 1.
  task automatic begin_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cycle);
    int guard;
    int bcnt;
    guard = 0;
    bcnt  = 0;
    while (bus.done !== 1'b1 && guard < 200) begin
      if (bus.busy === 1'b1) bcnt++;
      tick();
      guard++;
    end
    check({tag, " done cycle"}, 64'(cyc), 64'(exp_cycle));
    check({tag, " busy cycles"}, 64'(bcnt), 64'd32);
    check({tag, " busy at done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int done_cnt;
    int first_done;

    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.a       = '0;
    bus.b       = '0;
    rst_n       = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("reset busy",   64'(bus.busy),      64'd0);
    check("reset done",   64'(bus.done),      64'd0);
    check("reset result", 64'(bus.result),    64'd0);
    check("reset zero",   64'(bus.zero),      64'd0);
    check("reset cout",   64'(bus.carry_out), 64'd0);
`ifdef SERIAL_ALU_OVF_EN
    check("reset ovf",    64'(bus.overflow),  64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // OR
    cyc = 0;
    begin_op(2'b01, 32'h0F0F_0000, 32'h00F0_F0F0);
    check("or busy c1", 64'(bus.busy), 64'd1);
    wait_done("or", 33);
    check("or result", 64'(bus.result),    64'h0FFF_F0F0);
    check("or zero",   64'(bus.zero),      64'd0);
    check("or cout",   64'(bus.carry_out), 64'd0);
    tick();
    check("or done pulse", 64'(bus.done),   64'd0);
    check("or held",       64'(bus.result), 64'h0FFF_F0F0);

    // ADD wrap to zero
    cyc = 0;
    begin_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_done("add", 33);
    check("add result", 64'(bus.result),    64'h0);
    check("add zero",   64'(bus.zero),      64'd1);
    check("add cout",   64'(bus.carry_out), 64'd1);
`ifdef SERIAL_ALU_OVF_EN
    check("add ovf",    64'(bus.overflow),  64'd0);
`endif
    tick();

    // SUB with borrow
    cyc = 0;
    begin_op(2'b11, 32'd5, 32'd7);
    wait_done("sub57", 33);
    check("sub57 result", 64'(bus.result),    64'hFFFF_FFFE);
    check("sub57 zero",   64'(bus.zero),      64'd0);
    check("sub57 cout",   64'(bus.carry_out), 64'd0);
`ifdef SERIAL_ALU_OVF_EN
    check("sub57 ovf",    64'(bus.overflow),  64'd0);
`endif
    tick();

    // SUB signed overflow
    cyc = 0;
    begin_op(2'b11, 32'h8000_0000, 32'h0000_0001);
    wait_done("subovf", 33);
    check("subovf result", 64'(bus.result),    64'h7FFF_FFFF);
    check("subovf cout",   64'(bus.carry_out), 64'd1);
`ifdef SERIAL_ALU_OVF_EN
    check("subovf ovf",    64'(bus.overflow),  64'd1);
`endif
    tick();

    // AND with start held high and inputs changed while busy
    cyc       = 0;
    bus.op    = 2'b00;
    bus.a     = 32'hFFFF_0000;
    bus.b     = 32'h0FF0_0FF0;
    bus.start = 1'b1;
    tick();
    check("hold busy c1", 64'(bus.busy), 64'd1);
    bus.op     = 2'b01;
    bus.a      = 32'h1234_5678;
    bus.b      = 32'h0000_0001;
    done_cnt   = 0;
    first_done = 0;
    while (cyc < 33) begin
      tick();
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = cyc;
      end
    end
    check("hold done count", 64'(done_cnt),   64'd1);
    check("hold done cycle", 64'(first_done), 64'd33);
    check("hold result",     64'(bus.result), 64'h0FF0_0000);
    tick();
    check("hold c34 busy",   64'(bus.busy),   64'd0);
    check("hold c34 done",   64'(bus.done),   64'd0);
    check("hold c34 result", 64'(bus.result), 64'h0FF0_0000);
    tick();
    check("hold c35 busy",   64'(bus.busy),   64'd1);
    bus.start = 1'b0;
    wait_done("hold second", 67);
    check("hold second result", 64'(bus.result), 64'h1234_5679);
    tick();

    // Reset in the middle of RUN
    cyc = 0;
    begin_op(2'b10, 32'd3, 32'd4);
    while (cyc < 10) tick();
    check("abort pre busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy",   64'(bus.busy),      64'd0);
    check("abort done",   64'(bus.done),      64'd0);
    check("abort result", 64'(bus.result),    64'd0);
    check("abort zero",   64'(bus.zero),      64'd0);
    check("abort cout",   64'(bus.carry_out), 64'd0);
    done_cnt = 0;
    repeat (3) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (30) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    check("abort no done", 64'(done_cnt), 64'd0);
    cyc = 0;
    begin_op(2'b10, 32'd3, 32'd4);
    wait_done("readd", 33);
    check("readd result", 64'(bus.result), 64'h7);
    check("readd zero",   64'(bus.zero),   64'd0);
    tick();

    // Back-to-back at the earliest accepted start
    cyc = 0;
    begin_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0000);
    wait_done("b2b first", 33);
    check("b2b first result", 64'(bus.result), 64'h0);
    check("b2b first zero",   64'(bus.zero),   64'd1);
    tick();
    begin_op(2'b01, 32'h0000_0001, 32'h0000_0002);
    check("b2b c35 busy", 64'(bus.busy), 64'd1);
    wait_done("b2b second", 67);
    check("b2b second result", 64'(bus.result), 64'h3);
    check("b2b second zero",   64'(bus.zero),   64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "simulation timeout");
  end
endmodule
